cla_seq_ctrl: RTL and testbench

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

---
 rtl/cla_seq_ctrl_pkg.sv | 20 ++
 rtl/cla_slice.sv | 42 ++++
 rtl/cla_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_ctrl_pkg.sv
// Shared constants for the sequential carry-lookahead adder controller.
// Holds the slice geometry, the FSM encoding and a small index-width helper.
package cla_seq_ctrl_pkg;

    localparam int CLA_NBIT   = 7;
    localparam int CLA_NSLICE = 4;
    localparam int CLA_W      = CLA_NBIT * CLA_NSLICE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cla_state_t;

    // Width of the slice index; a single-slice build still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational NBIT-wide carry-lookahead adder slice.
// Every carry is a flat sum of generate/propagate products, so there is no ripple chain.
module cla_slice
    import cla_seq_ctrl_pkg::*;
#(
    parameter int NBIT = CLA_NBIT
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic [NBIT-1:0] s,
    output logic            cout
);

    logic [NBIT-1:0] g;
    logic [NBIT-1:0] p;
    logic [NBIT:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
    always_comb begin
        logic pp;
        pp   = 1'b0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < NBIT; i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end

    assign s    = p ^ c[NBIT-1:0];
    assign cout = c[NBIT];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Sequential wide adder: one shared cla_slice, stepped over NSLICE slices per operation.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | ready for a new operand pair; sum/cout hold the last result
//   RUN     | adding slice k of the latched operands, one slice per cycle
//   DONE    | result valid, held until out_ready or flush
module cla_seq_ctrl
    import cla_seq_ctrl_pkg::*;
#(
    parameter int NBIT   = CLA_NBIT,
    parameter int NSLICE = CLA_NSLICE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBIT*NSLICE-1:0] a,
    input  logic [NBIT*NSLICE-1:0] b,
    input  logic                   cin,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBIT*NSLICE-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int W  = NBIT * NSLICE;
    localparam int KW = idx_width(NSLICE);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    cla_state_t state_q;
    cla_state_t state_d;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [KW-1:0]   k_q;
    logic            carry_q;
    logic            cout_q;

    logic [NBIT-1:0] sl_a;
    logic [NBIT-1:0] sl_b;
    logic [NBIT-1:0] sl_s;
    logic            sl_co;
    logic            last_slice;

    assign sl_a       = a_q[k_q*NBIT +: NBIT];
    assign sl_b       = b_q[k_q*NBIT +: NBIT];
    assign last_slice = (k_q == K_LAST);

    cla_slice #(
        .NBIT (NBIT)
    ) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // flush outranks both slice completion and the output handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (last_slice) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        k_q     <= '0;
                        sum_q   <= '0;
                    end
                end
                ST_RUN: begin
                    // a flushed slice is dropped so sum/cout keep their previous contents
                    if (!flush) begin
                        sum_q[k_q*NBIT +: NBIT] <= sl_s;
                        carry_q                 <= sl_co;
                        if (last_slice) begin
                            k_q    <= '0;
                            cout_q <= sl_co;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench for cla_seq_ctrl: expected {cout,sum} queued on acceptance,
// popped and compared when out_valid appears.
module tb_cla_seq_ctrl;
    import cla_seq_ctrl_pkg::*;

    localparam int NBIT   = CLA_NBIT;
    localparam int NSLICE = CLA_NSLICE;
    localparam int W      = NBIT * NSLICE;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W:0] exp_q[$];
    logic [W:0] exp_v;
    int         lat;
    int         nvalid;

    always #5 clk = ~clk;

    cla_seq_ctrl #(
        .NBIT   (NBIT),
        .NSLICE (NSLICE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Drive one operation for a single edge (caller guarantees IDLE), then scramble inputs.
    task automatic send_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
        a        = ai;
        b        = bi;
        cin      = ci;
        in_valid = 1'b1;
        exp_q.push_back({1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci});
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic pop_exp(output logic [W:0] v);
        if (exp_q.size() > 0) v = exp_q.pop_front();
        else v = 'x;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #12;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if ({cout, sum} !== '0) $display("FAIL reset_result: got %h want 0", {cout, sum});
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    // First edge after reset release accepts 1+1; result one cycle wide.
    task automatic test_basic();
        out_ready = 1'b1;
        send_op(28'h0000001, 28'h0000001, 1'b0);
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL basic_accept: got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
        else pass_cnt++;
        wait_out(lat);
        total_cnt++;
        if (lat != NSLICE) $display("FAIL basic_latency: got %0d want %0d", lat, NSLICE);
        else pass_cnt++;
        pop_exp(exp_v);
        total_cnt++;
        if ({cout, sum} !== exp_v) $display("FAIL basic_result: got %h want %h", {cout, sum}, exp_v);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL basic_pulse: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_ripple();
        out_ready = 1'b1;
        send_op(28'hFFFFFFF, 28'h0000000, 1'b1);
        wait_out(lat);
        total_cnt++;
        if (lat != NSLICE) $display("FAIL ripple_latency: got %0d want %0d", lat, NSLICE);
        else pass_cnt++;
        pop_exp(exp_v);
        total_cnt++;
        if ({cout, sum} !== exp_v) $display("FAIL ripple_result: got %h want %h", {cout, sum}, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (cout !== 1'b1 || sum !== '0) $display("FAIL ripple_cout: got cout=%b sum=%h want 1/0", cout, sum);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    // Stalled output with in_valid and garbage operands held high during the operation.
    task automatic test_backpressure();
        out_ready = 1'b0;
        send_op(28'h5555555, 28'hAAAAAAA, 1'b1);
        in_valid = 1'b1;
        wait_out(lat);
        total_cnt++;
        if (lat != NSLICE) $display("FAIL bp_latency: got %0d want %0d", lat, NSLICE);
        else pass_cnt++;
        pop_exp(exp_v);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp_v)
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b res=%h want 1/0/%h",
                         i, out_valid, in_ready, {cout, sum}, exp_v);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_idle: got ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_op(28'h0000123, 28'h0000456, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rstmid_ctrl: got valid=%b busy=%b ready=%b want 0/0/1", out_valid, busy, in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({cout, sum} !== '0) $display("FAIL rstmid_result: got %h want 0", {cout, sum});
        else pass_cnt++;
        void'(exp_q.pop_back());
        #2;
        rst_n  = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) nvalid++;
        end
        total_cnt++;
        if (nvalid != 0 || in_ready !== 1'b1)
            $display("FAIL rstmid_novalid: got pulses=%0d ready=%b want 0/1", nvalid, in_ready);
        else pass_cnt++;
        send_op(28'h0000003, 28'h0000004, 1'b0);
        wait_out(lat);
        pop_exp(exp_v);
        total_cnt++;
        if (lat != NSLICE || {cout, sum} !== exp_v)
            $display("FAIL rstmid_next: got lat=%0d res=%h want %0d/%h", lat, {cout, sum}, NSLICE, exp_v);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send_op(28'h0000777, 28'h0000111, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL flush_idle: got ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid);
        else pass_cnt++;
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) nvalid++;
        end
        total_cnt++;
        if (nvalid != 0) $display("FAIL flush_novalid: got pulses=%0d want 0", nvalid);
        else pass_cnt++;
        // flush while IDLE must not block acceptance
        flush = 1'b1;
        send_op(28'h0000080, 28'h0000080, 1'b0);
        flush = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL flush_idle_accept: got busy=%b want 1", busy);
        else pass_cnt++;
        wait_out(lat);
        pop_exp(exp_v);
        total_cnt++;
        if (lat != NSLICE || {cout, sum} !== exp_v)
            $display("FAIL flush_next: got lat=%0d res=%h want %0d/%h", lat, {cout, sum}, NSLICE, exp_v);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    // Flush in DONE retains the result; flush on the last RUN slice suppresses DONE.
    task automatic test_flush_done();
        out_ready = 1'b0;
        send_op(28'h1234567, 28'h0FEDCBA, 1'b1);
        wait_out(lat);
        pop_exp(exp_v);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || {cout, sum} !== exp_v)
            $display("FAIL flushdone: got valid=%b ready=%b res=%h want 0/1/%h",
                     out_valid, in_ready, {cout, sum}, exp_v);
        else pass_cnt++;
        send_op(28'h0000010, 28'h0000020, 1'b0);
        for (int i = 0; i < NSLICE - 1; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flushlast: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ra = (i == 0) ? '1 : W'($urandom);
            rb = (i == 0) ? '1 : W'($urandom);
            rc = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            send_op(ra, rb, rc);
            wait_out(lat);
            pop_exp(exp_v);
            total_cnt++;
            if (lat != NSLICE || {cout, sum} !== exp_v)
                $display("FAIL b2b[%0d]: got lat=%0d res=%h want %0d/%h", i, lat, {cout, sum}, NSLICE, exp_v);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_reset_mid();
        test_flush();
        test_flush_done();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
